// File: rtl/sound_mix_sched.sv
// Six-slot stereo mixer: one shared signed MAC per frame, per-source gain, saturation to 16 bits.
// Optional build macro MIX_RAMP_EN adds per-source gain ramping (one step per accepted frame).
module sound_mix_sched #(
    parameter int GAIN_W     = 5,
    parameter int GAIN_SHIFT = 4,
    parameter int ACC_W      = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_ce,
    input  logic signed [15:0]       dsp_l,
    input  logic signed [15:0]       dsp_r,
    input  logic signed [15:0]       opl_l,
    input  logic signed [15:0]       opl_r,
    input  logic signed [15:0]       cms_l,
    input  logic signed [15:0]       cms_r,
    input  logic        [GAIN_W-1:0] gain_dsp,
    input  logic        [GAIN_W-1:0] gain_opl,
    input  logic        [GAIN_W-1:0] gain_cms,
    input  logic        [2:0]        src_en,
    output logic signed [15:0]       sample_l,
    output logic signed [15:0]       sample_r,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int PROD_W = 16 + GAIN_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               slot_q, slot_d;
    logic signed [15:0]       smp_q [6];
    logic [GAIN_W-1:0]        gain_q [3];
    logic [2:0]               en_q;
    logic signed [ACC_W-1:0]  acc_l_q, acc_r_q;
    logic signed [15:0]       sample_l_q, sample_r_q;
    logic                     out_valid_q, overrun_q;

    logic                     frame_start;
    logic [GAIN_W-1:0]        gain_tgt  [3];
    logic [GAIN_W-1:0]        gain_snap [3];
    logic signed [15:0]       mult_src;
    logic [GAIN_W-1:0]        mult_gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  addend;

    assign frame_start = (state_q == S_IDLE) && sample_ce;
    assign gain_tgt[0] = gain_dsp;
    assign gain_tgt[1] = gain_opl;
    assign gain_tgt[2] = gain_cms;

`ifdef MIX_RAMP_EN
    logic [GAIN_W-1:0] eff_q [3];
    logic [GAIN_W-1:0] eff_d [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eff_d[i] = eff_q[i];
            if (eff_q[i] < gain_tgt[i])      eff_d[i] = eff_q[i] + 1'b1;
            else if (eff_q[i] > gain_tgt[i]) eff_d[i] = eff_q[i] - 1'b1;
            gain_snap[i] = eff_d[i];
        end
    end

    // Effective gains only move on accepted frames, so reset fades the mix in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) eff_q[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < 3; i++) eff_q[i] <= eff_d[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 3; i++) gain_snap[i] = gain_tgt[i];
    end
`endif

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            S_IDLE: if (sample_ce) begin
                state_d = S_MAC;
                slot_d  = 3'd0;
            end
            S_MAC: begin
                if (slot_q == 3'd5) state_d = S_SAT;
                else                slot_d  = slot_q + 3'd1;
            end
            S_SAT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Slot pairs share a source: slot>>1 picks gain and enable, slot[0] picks the channel.
    assign mult_src  = smp_q[slot_q];
    assign mult_gain = gain_q[slot_q[2:1]];
    assign prod      = mult_src * $signed({1'b0, mult_gain});
    assign addend    = en_q[slot_q[2:1]] ? ACC_W'(prod) : '0;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 16'sh7FFF;
        else if (v < SAT_MIN) return 16'sh8000;
        else                  return v[15:0];
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            en_q        <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            // NOTE: snapshot arrays are tiny register files, so they are reset with everything else.
            for (int i = 0; i < 6; i++) smp_q[i]  <= '0;
            for (int i = 0; i < 3; i++) gain_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid_q <= (state_q == S_SAT);
            overrun_q   <= sample_ce && (state_q != S_IDLE);
            if (frame_start) begin
                smp_q[0] <= dsp_l;
                smp_q[1] <= dsp_r;
                smp_q[2] <= opl_l;
                smp_q[3] <= opl_r;
                smp_q[4] <= cms_l;
                smp_q[5] <= cms_r;
                for (int i = 0; i < 3; i++) gain_q[i] <= gain_snap[i];
                en_q     <= src_en;
                acc_l_q  <= '0;
                acc_r_q  <= '0;
            end else if (state_q == S_MAC) begin
                if (slot_q[0]) acc_r_q <= acc_r_q + addend;
                else           acc_l_q <= acc_l_q + addend;
            end
            if (state_q == S_SAT) begin
                sample_l_q <= sat16(acc_l_q >>> GAIN_SHIFT);
                sample_r_q <= sat16(acc_r_q >>> GAIN_SHIFT);
            end
        end
    end

    assign sample_l  = sample_l_q;
    assign sample_r  = sample_r_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sound_mix_sched.sv
// Randomized bench for sound_mix_sched against an arithmetic mix model; honours MIX_RAMP_EN.
module tb_sound_mix_sched;

    localparam int GAIN_SHIFT = 4;

    logic              clk, rst_n, sample_ce;
    logic signed [15:0] dsp_l, dsp_r, opl_l, opl_r, cms_l, cms_r;
    logic        [4:0]  gain_dsp, gain_opl, gain_cms;
    logic        [2:0]  src_en;
    logic signed [15:0] sample_l, sample_r;
    logic               out_valid, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int eff [3];
    int last_l, last_r;

    sound_mix_sched dut (
        .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce),
        .dsp_l(dsp_l), .dsp_r(dsp_r), .opl_l(opl_l), .opl_r(opl_r),
        .cms_l(cms_l), .cms_r(cms_r),
        .gain_dsp(gain_dsp), .gain_opl(gain_opl), .gain_cms(gain_cms),
        .src_en(src_en),
        .sample_l(sample_l), .sample_r(sample_r),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Expected mix from the inputs present at the accepting edge; steps ramp gains when enabled.
    task automatic model_frame(output int el, output int er);
        int tgt [3];
        int g   [3];
        int sl  [3];
        int sr  [3];
        int suml, sumr;
        tgt = '{int'(gain_dsp), int'(gain_opl), int'(gain_cms)};
        sl  = '{int'(dsp_l), int'(opl_l), int'(cms_l)};
        sr  = '{int'(dsp_r), int'(opl_r), int'(cms_r)};
        suml = 0;
        sumr = 0;
        for (int i = 0; i < 3; i++) begin
`ifdef MIX_RAMP_EN
            if (eff[i] < tgt[i])      eff[i]++;
            else if (eff[i] > tgt[i]) eff[i]--;
            g[i] = eff[i];
`else
            g[i] = tgt[i];
`endif
            if (src_en[i]) begin
                suml += sl[i] * g[i];
                sumr += sr[i] * g[i];
            end
        end
        el = clamp16(suml >>> GAIN_SHIFT);
        er = clamp16(sumr >>> GAIN_SHIFT);
    endtask

    task automatic set_in(input int l0, input int r0, input int l1, input int r1,
                          input int l2, input int r2, input int gd, input int go,
                          input int gc, input int en);
        dsp_l = 16'(l0); dsp_r = 16'(r0);
        opl_l = 16'(l1); opl_r = 16'(r1);
        cms_l = 16'(l2); cms_r = 16'(r2);
        gain_dsp = 5'(gd); gain_opl = 5'(go); gain_cms = 5'(gc);
        src_en = 3'(en);
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(0, 5))
            0:       return 32767;
            1:       return -32768;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    task automatic scramble();
        set_in(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(),
               rnd_sample(), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 7));
    endtask

    // Called at a negedge; strobes one frame and optionally a second strobe at cycle ovr_at.
    task automatic do_frame(input string tag, input int ovr_at);
        int el, er, cyc, busy_n, ovr_n;
        model_frame(el, er);
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
        scramble();
        cyc = 1; busy_n = 0; ovr_n = 0;
        while (!out_valid && cyc < 20) begin
            if (busy)    busy_n++;
            if (overrun) ovr_n++;
            if (cyc == ovr_at) sample_ce = 1'b1;
            @(negedge clk);
            sample_ce = 1'b0;
            cyc++;
        end
        if (overrun) ovr_n++;
        check({tag, "_latency"}, cyc - 1, 7);
        check({tag, "_busy_cycles"}, busy_n, 7);
        check({tag, "_overrun"}, ovr_n, (ovr_at > 0) ? 1 : 0);
        check({tag, "_l"}, int'(sample_l), el);
        check({tag, "_r"}, int'(sample_r), er);
        last_l = el;
        last_r = er;
    endtask

    // Idle cycles: no out_valid, outputs hold.
    task automatic idle(input string tag, input int n);
        int ov_n;
        ov_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) ov_n++;
        end
        check({tag, "_no_valid"}, ov_n, 0);
        check({tag, "_hold_l"}, int'(sample_l), last_l);
        check({tag, "_hold_r"}, int'(sample_r), last_r);
    endtask

    task automatic test1_inputs();
        set_in(16'h1000, 0, 0, 0, 0, 0, 16, 16, 16, 7);
    endtask

    initial begin
        rst_n = 1'b0;
        sample_ce = 1'b0;
        eff = '{0, 0, 0};
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_l", int'(sample_l), 0);
        check("reset_r", int'(sample_r), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef MIX_RAMP_EN
        test1_inputs();
        do_frame("t1", 0);
        check("t1_lit_l", int'(sample_l), 32'h1000);
        check("t1_lit_r", int'(sample_r), 0);
        idle("t1_idle", 3);

        set_in(16'h7000, 0, 16'h7000, 0, 16'h7000, 0, 16, 16, 16, 7);
        do_frame("t2_pos", 0);
        check("t2_lit_pos", int'(sample_l), 32767);
        set_in(16'h9000, 0, 16'h9000, 0, 16'h9000, 0, 16, 16, 16, 7);
        do_frame("t2_neg", 0);
        check("t2_lit_neg", int'(sample_l), -32768);

        set_in(16'h1000, 0, 16'h0800, 0, 0, 0, 16, 16, 16, 3'b010);
        do_frame("t3_mask", 0);
        check("t3_lit_mask", int'(sample_l), 32'h0800);
        set_in(16'h1000, 0, 16'h0800, 0, 0, 0, 16, 0, 16, 7);
        do_frame("t3_mute", 0);
        check("t3_lit_mute", int'(sample_l), 32'h1000);
        set_in(16'h1000, 0, 16'h0800, 0, 0, 0, 8, 0, 16, 7);
        do_frame("t3_half", 0);
        check("t3_lit_half", int'(sample_l), 32'h0800);
`endif

        set_in(16'h1234, -300, 0, 16'h0100, 0, 0, 16, 16, 16, 7);
        do_frame("t4_overrun", 3);
        idle("t4_idle", 10);
        set_in(1000, -1000, 2000, -2000, 3000, -3000, 16, 16, 16, 7);
        do_frame("t4_sat_overrun", 7);
        idle("t4b_idle", 4);

        test1_inputs();
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_l", int'(sample_l), 0);
        check("t5_rst_r", int'(sample_r), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_valid", int'(out_valid), 0);
        eff = '{0, 0, 0};
        last_l = 0;
        last_r = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("t5_aborted", 10);

`ifdef MIX_RAMP_EN
        for (int k = 1; k <= 20; k++) begin
            set_in(16'h1000, 0, 0, 0, 0, 0, 16, 0, 0, 7);
            do_frame("t6_up", 0);
            check("t6_lit_up", int'(sample_l), (k < 16 ? k : 16) * 32'h100);
        end
        for (int k = 1; k <= 6; k++) begin
            set_in(16'h1000, 0, 0, 0, 0, 0, 12, 0, 0, 7);
            do_frame("t6_down", 0);
            check("t6_lit_down", int'(sample_l), (k < 4 ? 16 - k : 12) * 32'h100);
        end
`else
        test1_inputs();
        do_frame("t5_after", 0);
        check("t5_lit_after", int'(sample_l), 32'h1000);
`endif

        for (int n = 0; n < 40; n++) begin
            int gap;
            scramble();
            do_frame("rand", ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle("rand_gap", gap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
